// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
//   UART transmitter. Accepts one parallel word per valid/ready handshake and
//   shifts it out on the tx pin as: start bit (0), DATA_BITS data bits LSB
//   first, an optional even-parity bit, then STOP_BITS stop bits (1).
//   tx only changes at bit boundaries, on the same edge as the state change.
//
// Parameters
//   CLKS_PER_BIT  clk cycles per bit period (>= 2)
//   DATA_BITS     data bits per frame (5..9)
//   PARITY_EN     1 = append even-parity bit, 0 = none
//   STOP_BITS     stop bits per frame (1 or 2)
//
// Ports
//   clk       in   single clock, all logic on posedge
//   rst       in   synchronous active-high reset; aborts any frame in flight
//   in_data   in   word to send, sampled only on the handshake edge
//   in_valid  in   in_data is valid
//   in_ready  out  block can accept a word (state IDLE)
//   tx        out  registered serial line, idle high
//   busy      out  frame in progress (state not IDLE)
//   tx_done   out  one-cycle pulse after the last stop bit completes
// -----------------------------------------------------------------------------
module uart_tx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8,
   parameter int PARITY_EN    = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [DATA_BITS-1:0] in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic                 tx,
   output logic                 busy,
   output logic                 tx_done
);

   // Reject illegal configurations at elaboration time.
   generate
      if (CLKS_PER_BIT < 2) begin : g_bad_cpb
         $error("uart_tx: CLKS_PER_BIT must be >= 2");
      end
      if ((DATA_BITS < 5) || (DATA_BITS > 9)) begin : g_bad_data
         $error("uart_tx: DATA_BITS must be 5..9");
      end
      if ((PARITY_EN != 0) && (PARITY_EN != 1)) begin : g_bad_par
         $error("uart_tx: PARITY_EN must be 0 or 1");
      end
      if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
         $error("uart_tx: STOP_BITS must be 1 or 2");
      end
   endgenerate

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   // Bit counter indexes both data bits and stop bits; DATA_BITS dominates.
   localparam int BIT_W  = $clog2(DATA_BITS + 1);

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_START  = 3'd1;
   localparam logic [2:0] S_DATA   = 3'd2;
   localparam logic [2:0] S_PARITY = 3'd3;
   localparam logic [2:0] S_STOP   = 3'd4;

   logic [2:0]           r_state;
   logic [BAUD_W-1:0]    r_baud;
   logic [BIT_W-1:0]     r_bit;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_parity;
   logic                 r_tx;
   logic                 r_done;

   logic w_bit_end;
   logic w_idle;

   assign w_bit_end = (r_baud == BAUD_LAST);
   assign w_idle    = (r_state == S_IDLE);

   assign in_ready = w_idle;
   assign busy     = ~w_idle;
   assign tx       = r_tx;
   assign tx_done  = r_done;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_baud   <= '0;
         r_bit    <= '0;
         r_shift  <= '0;
         r_parity <= 1'b0;
         r_tx     <= 1'b1;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_baud <= '0;
               r_bit  <= '0;
               r_tx   <= 1'b1;
               // in_ready is 1 here, so in_valid alone completes the handshake.
               if (in_valid) begin
                  r_shift  <= in_data;
                  r_parity <= ^in_data;
                  r_tx     <= 1'b0;
                  r_state  <= S_START;
               end
            end

            S_START: begin
               if (w_bit_end) begin
                  r_baud  <= '0;
                  r_tx    <= r_shift[0];
                  r_state <= S_DATA;
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end

            S_DATA: begin
               if (w_bit_end) begin
                  r_baud <= '0;
                  if (r_bit == DATA_LAST) begin
                     r_bit <= '0;
                     if (PARITY_EN != 0) begin
                        r_tx    <= r_parity;
                        r_state <= S_PARITY;
                     end else begin
                        r_tx    <= 1'b1;
                        r_state <= S_STOP;
                     end
                  end else begin
                     r_bit   <= r_bit + 1'b1;
                     // Bit 0 is on the line now; bit 1 becomes the next one.
                     r_shift <= r_shift >> 1;
                     r_tx    <= r_shift[1];
                  end
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end

            S_PARITY: begin
               if (w_bit_end) begin
                  r_baud  <= '0;
                  r_tx    <= 1'b1;
                  r_state <= S_STOP;
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end

            S_STOP: begin
               if (w_bit_end) begin
                  r_baud <= '0;
                  if (r_bit == STOP_LAST) begin
                     r_bit   <= '0;
                     r_done  <= 1'b1;
                     r_state <= S_IDLE;
                  end else begin
                     r_bit <= r_bit + 1'b1;
                  end
               end else begin
                  r_baud <= r_baud + 1'b1;
               end
            end

            default: begin
               r_state <= S_IDLE;
               r_baud  <= '0;
               r_bit   <= '0;
               r_tx    <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
//   Three uart_tx instances with different configurations share one clock and
//   reset; one is exercised at a time. Words are pushed to a scoreboard queue
//   when their handshake is seen; a line monitor pops them at each start bit
//   and checks every bit period of the frame plus the tx_done pulse timing.
//   dut_a: CLKS_PER_BIT=4, 8N1
//   dut_b: CLKS_PER_BIT=4, 8 data, even parity, 1 stop
//   dut_c: CLKS_PER_BIT=3, 7 data, even parity, 2 stop
// -----------------------------------------------------------------------------
module tb_uart_tx;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [8:0] d   = '0;
   logic       va = 1'b0, vb = 1'b0, vc = 1'b0;
   logic       ready_a, ready_b, ready_c;
   logic       tx_a, tx_b, tx_c;
   logic       busy_a, busy_b, busy_c;
   logic       done_a, done_b, done_c;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(0), .STOP_BITS(1)) dut_a (
      .clk(clk), .rst(rst), .in_data(d[7:0]), .in_valid(va), .in_ready(ready_a),
      .tx(tx_a), .busy(busy_a), .tx_done(done_a));

   uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .STOP_BITS(1)) dut_b (
      .clk(clk), .rst(rst), .in_data(d[7:0]), .in_valid(vb), .in_ready(ready_b),
      .tx(tx_b), .busy(busy_b), .tx_done(done_b));

   uart_tx #(.CLKS_PER_BIT(3), .DATA_BITS(7), .PARITY_EN(1), .STOP_BITS(2)) dut_c (
      .clk(clk), .rst(rst), .in_data(d[6:0]), .in_valid(vc), .in_ready(ready_c),
      .tx(tx_c), .busy(busy_c), .tx_done(done_c));

   int n_checks = 0;
   int n_errors = 0;

   // Active instance and its configuration, as seen by the monitor.
   int phase   = 0;
   int p_cpb   = 4;
   int p_dbits = 8;
   int p_par   = 0;
   int p_stops = 1;

   logic [8:0] exp_q[$];
   bit mon_en     = 1'b0;
   bit mon_busy   = 1'b0;
   int last_start = -1;
   int last_done  = -1;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic tx_cur();
      case (phase)
         0: return tx_a;
         1: return tx_b;
         default: return tx_c;
      endcase
   endfunction

   function automatic logic done_cur();
      case (phase)
         0: return done_a;
         1: return done_b;
         default: return done_c;
      endcase
   endfunction

   function automatic logic ready_cur();
      case (phase)
         0: return ready_a;
         1: return ready_b;
         default: return ready_c;
      endcase
   endfunction

   function automatic logic busy_cur();
      case (phase)
         0: return busy_a;
         1: return busy_b;
         default: return busy_c;
      endcase
   endfunction

   task automatic set_valid(input logic v);
      case (phase)
         0: va = v;
         1: vb = v;
         default: vc = v;
      endcase
   endtask

   task automatic set_phase(input int ph, input int cpb, input int dbits, input int par, input int stops);
      phase = ph; p_cpb = cpb; p_dbits = dbits; p_par = par; p_stops = stops;
   endtask

   // Present a word and wait for the handshake; k is the handshake cycle.
   task automatic send(input logic [8:0] w, input bit hold, input bit push, output int k);
      int n;
      logic [8:0] mask;
      mask = 9'((1 << p_dbits) - 1);
      @(negedge clk);
      d = w;
      set_valid(1'b1);
      n = 0;
      while (!ready_cur() && n < 300) begin
         @(negedge clk);
         n++;
      end
      check_val("handshake_wait", 32'(n < 300), 1);
      k = cyc;
      if (push) exp_q.push_back(w & mask);
      $display("send dut%0d word=%0h handshake cycle=%0d", phase, w & mask, k);
      @(posedge clk);
      #1;
      if (!hold) set_valid(1'b0);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || mon_busy) && n < 600) begin
         @(negedge clk);
         n++;
      end
      check_val("drain_wait", 32'(n < 600), 1);
      repeat (2) @(negedge clk);
   endtask

   // Line monitor: decode each frame bit by bit against the scoreboard.
   initial begin : monitor
      logic [8:0] w;
      logic       expb, got;
      bit         done_seen;
      int         nbits;
      forever begin
         @(negedge clk);
         if (mon_en && !rst && tx_cur() == 1'b0) begin
            mon_busy   = 1'b1;
            last_start = cyc;
            check_val("frame_expected", 32'(exp_q.size() != 0), 1);
            w = (exp_q.size() != 0) ? exp_q.pop_front() : 9'h0;
            nbits = 1 + p_dbits + p_par + p_stops;
            done_seen = 1'b0;
            for (int b = 0; b < nbits; b++) begin
               if (b == 0)                         expb = 1'b0;
               else if (b <= p_dbits)              expb = w[b-1];
               else if (p_par != 0 && b == p_dbits + 1) expb = ^w;
               else                                expb = 1'b1;
               got = expb;
               for (int c = 0; c < p_cpb; c++) begin
                  if (b != 0 || c != 0) @(negedge clk);
                  if (tx_cur() !== expb) got = tx_cur();
                  if (done_cur() !== 1'b0) done_seen = 1'b1;
               end
               check_val($sformatf("word%0h_bit%0d", w, b), 32'(got), 32'(expb));
            end
            check_val("no_early_done", 32'(done_seen), 0);
            @(negedge clk);
            last_done = cyc;
            check_val("tx_done_pulse", 32'(done_cur()), 1);
            check_val("tx_idle_after_frame", 32'(tx_cur()), 1);
            check_val("ready_in_done_cycle", 32'(ready_cur()), 1);
            $display("frame dut%0d word=%0h start=%0d done=%0d", phase, w, last_start, last_done);
            mon_busy = 1'b0;
         end
      end
   end

   initial begin : stim
      int k, k1, k2;
      bit bad;
      logic [8:0] w;

      // Reset state of all three instances.
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_val("rst_tx_a", 32'(tx_a), 1);
      check_val("rst_busy_a", 32'(busy_a), 0);
      check_val("rst_ready_a", 32'(ready_a), 1);
      check_val("rst_done_a", 32'(done_a), 0);
      check_val("rst_tx_b", 32'(tx_b), 1);
      check_val("rst_tx_c", 32'(tx_c), 1);
      check_val("rst_done_c", 32'(done_c), 0);
      rst = 1'b0;
      mon_en = 1'b1;
      repeat (2) @(negedge clk);

      // 8N1, 4 clk/bit: 0xA5, tx_done 41 cycles after the handshake.
      set_phase(0, 4, 8, 0, 1);
      send(9'h0A5, 1'b0, 1'b1, k);
      @(negedge clk);
      check_val("busy_in_frame", 32'(busy_a), 1);
      check_val("ready_in_frame", 32'(ready_a), 0);
      wait_idle();
      check_val("a5_first_low", 32'(last_start), 32'(k + 1));
      check_val("a5_done_cycle", 32'(last_done), 32'(k + 41));

      // in_valid held high: second frame starts right after the tx_done cycle.
      send(9'h011, 1'b1, 1'b1, k1);
      send(9'h022, 1'b0, 1'b1, k2);
      wait_idle();
      check_val("b2b_handshake", 32'(k2), 32'(k1 + 41));
      check_val("b2b_second_start", 32'(last_start), 32'(k2 + 1));

      // in_valid pulse during DATA is ignored; no second frame.
      send(9'h03C, 1'b0, 1'b1, k);
      repeat (9) @(negedge clk);
      d  = 9'h0FF;
      va = 1'b1;
      check_val("ready_while_busy", 32'(ready_a), 0);
      @(negedge clk);
      va = 1'b0;
      wait_idle();
      repeat (60) @(negedge clk);
      check_val("no_extra_frame", 32'(exp_q.size()), 0);
      check_val("idle_after_ignore", 32'(busy_a), 0);

      // Reset during data bit 3 of 0x00 aborts the frame.
      mon_en = 1'b0;
      send(9'h000, 1'b0, 1'b0, k);
      do @(negedge clk); while (cyc < k + 18);
      check_val("abort_tx_low_before", 32'(tx_a), 0);
      rst = 1'b1;
      @(negedge clk);
      check_val("abort_tx_high", 32'(tx_a), 1);
      check_val("abort_busy", 32'(busy_a), 0);
      check_val("abort_ready", 32'(ready_a), 1);
      check_val("abort_done", 32'(done_a), 0);
      rst = 1'b0;
      bad = 1'b0;
      repeat (60) begin
         @(negedge clk);
         if (done_a !== 1'b0 || tx_a !== 1'b1) bad = 1'b1;
      end
      check_val("abort_no_retry", 32'(bad), 0);
      mon_en = 1'b1;
      send(9'h05A, 1'b0, 1'b1, k);
      wait_idle();
      check_val("post_abort_done", 32'(last_done), 32'(k + 41));

      // Even parity: 0x07 -> parity 1, 0x03 -> parity 0; frame 44 cycles.
      set_phase(1, 4, 8, 1, 1);
      send(9'h007, 1'b0, 1'b1, k);
      wait_idle();
      check_val("par07_done_cycle", 32'(last_done), 32'(k + 45));
      send(9'h003, 1'b0, 1'b1, k);
      wait_idle();
      check_val("par03_done_cycle", 32'(last_done), 32'(k + 45));

      // Two stop bits, 7 data, parity, 3 clk/bit: random words.
      set_phase(2, 3, 7, 1, 2);
      for (int i = 0; i < 8; i++) begin
         w = 9'($urandom_range(0, 127));
         send(w, 1'b0, 1'b1, k);
         if ($urandom_range(0, 1) == 1) repeat ($urandom_range(0, 40)) @(negedge clk);
      end
      wait_idle();
      check_val("c_last_done_cycle", 32'(last_done), 32'(k + 34));
      check_val("c_idle", 32'(busy_cur()), 0);
      check_val("scoreboard_empty", 32'(exp_q.size()), 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   // Global time limit so the bench always terminates.
   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
      $fatal(1, "timeout");
   end

endmodule
